// File: rtl/bus_pkg.sv
// bus_pkg: shared FSM encoding, bus constants and round-robin index helper for bus_arbiter.
package bus_pkg;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam int ADDR_W      = 8;
  localparam int NUM_REQ_DEF = 4;
  function automatic int rr_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction
endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/grant bundle between the cache-side requesters (master) and the arbiter (slave).
interface bus_arbiter_if
  import bus_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] gnt;
  logic               bus_busy;
  logic [ID_W-1:0]    owner_id;
  logic               timeout_err;
  modport master(output req, done, input gnt, bus_busy, owner_id, timeout_err);
  modport slave(input req, done, output gnt, bus_busy, owner_id, timeout_err);
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin select; first set req at or after ptr (wrapping) wins.
module rr_pick
  import bus_pkg::*;
#(
  parameter int N = NUM_REQ_DEF,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         valid
);
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid && req[rr_idx(int'(ptr), i, N)]) begin
        valid = 1'b1;
        idx   = W'(rr_idx(int'(ptr), i, N));
        onehot[rr_idx(int'(ptr), i, N)] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of the shared address bus, IDLE/GRANT/RELEASE with one turnaround cycle.
// Define BUS_ARB_TIMEOUT_EN to bound each tenure to TIMEOUT_CYC grant cycles.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input logic clk,
  input logic rst,
  bus_arbiter_if.slave bus
);
  if (ID_W != $clog2(NUM_REQ) || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("bus_arbiter: ID_W must be clog2(NUM_REQ) and TIMEOUT_CYC at least 2");
  end
  logic [1:0]         state;
  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] gnt;
  logic               busy;
  logic [ID_W-1:0]    owner;
  logic               terr;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_valid;
  logic               own_req;
  logic               own_done;
  logic               expire;
  rr_pick #(.N(NUM_REQ), .W(ID_W)) u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .onehot(pick_onehot),
    .idx   (pick_idx),
    .valid (pick_valid)
  );
  assign own_req  = bus.req[owner];
  assign own_done = bus.done[owner];
`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] cnt;
  assign expire = cnt == CNT_W'(TIMEOUT_CYC - 1);
  // Holding the count at zero in IDLE makes it read zero on the first grant cycle.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt  <= '0;
      terr <= 1'b0;
    end else begin
      cnt  <= (state == GRANT) ? cnt + CNT_W'(1) : '0;
      terr <= (state == GRANT) && expire && own_req && !own_done;
    end
`else
  assign expire = 1'b0;
  assign terr   = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      gnt   <= '0;
      busy  <= 1'b0;
      owner <= '0;
      ptr   <= '0;
    end else if (state == IDLE) begin
      if (pick_valid) begin
        gnt   <= pick_onehot;
        busy  <= 1'b1;
        owner <= pick_idx;
        state <= GRANT;
      end
    end else if (state == GRANT) begin
      if (own_done || !own_req || expire) begin
        gnt   <= '0;
        busy  <= 1'b0;
        ptr   <= (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + ID_W'(1);
        state <= RELEASE;
      end
    end else begin
      state <= IDLE;
    end
  assign bus.gnt         = gnt;
  assign bus.bus_busy    = busy;
  assign bus.owner_id    = owner;
  assign bus.timeout_err = terr;
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of cache-side requesters sharing the 8-bit address bus.
REQ-002 Parameter ID_W, default 2: width of the owner index; SHALL equal clog2(NUM_REQ).
REQ-003 Parameter TIMEOUT_CYC, default 16: maximum tenure length in cycles.
REQ-004 clk  input  1  single clock; all state changes on posedge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NUM_REQ  per-requester bus request, level, held until grant plus done.
REQ-007 done  input  NUM_REQ  per-requester end-of-tenure, 1-cycle pulse, valid only from current owner.
REQ-008 gnt  output  NUM_REQ  one-hot registered grant; all zero when bus is free.
REQ-009 bus_busy  output  1  high while any gnt bit is set.
REQ-010 owner_id  output  ID_W  index of current grantee; holds last owner when free.
REQ-011 timeout_err  output  1  1-cycle pulse when a tenure is forcibly ended.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT, RELEASE.
REQ-013 IDLE: if any req bit is high, select the winner, load gnt/owner_id, and go to GRANT; grant appears 1 cycle after req is sampled high.
REQ-014 Arbitration SHALL be round-robin: search starts at index (ptr), wraps modulo NUM_REQ, first set req wins.
REQ-015 ptr SHALL update to (owner_id+1) mod NUM_REQ on entry to RELEASE.
REQ-016 GRANT: gnt held constant; exit to RELEASE when done[owner_id]=1 or req[owner_id]=0.
REQ-017 done on a non-owner index SHALL be ignored.
REQ-018 RELEASE: gnt all zero, bus_busy=0 for exactly one turnaround cycle, so the tristated bus is not driven by two owners; then go to IDLE unconditionally.
REQ-019 Minimum gap between two tenures SHALL be 2 cycles (RELEASE + IDLE).
REQ-020 A req that rises in the same cycle as a done SHALL compete in the next IDLE arbitration, not preempt.
REQ-021 gnt SHALL never have more than one bit set in any cycle.

Reset
REQ-022 While rst=0: state=IDLE, gnt=0, bus_busy=0, owner_id=0, ptr=0, timeout counter=0, timeout_err=0.
REQ-023 Reset asserted mid-tenure SHALL drop gnt in the same cycle (asynchronously), with no RELEASE cycle.
REQ-024 First arbitration after reset SHALL favour index 0.

Configuration
REQ-025 Macro BUS_ARB_TIMEOUT_EN compiles the tenure watchdog in.
REQ-026 With the macro: a counter clears on entry to GRANT and increments each GRANT cycle; at count TIMEOUT_CYC-1 without done, force RELEASE and pulse timeout_err together with the RELEASE cycle.
REQ-027 Without the macro: no counter exists; timeout_err SHALL be tied to 0; tenure is unbounded.

Structure
REQ-028 Shared package bus_pkg SHALL hold the state encoding (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2), the bus address width constant 8, and the default NUM_REQ.
REQ-029 Sub-module rr_pick (combinational round-robin priority select: req, ptr -> one-hot, index, valid) SHALL be instantiated once.
REQ-030 All outputs SHALL be registered; no combinational path from req/done to gnt.

Verification
REQ-031 Single requester: req=4'b0100 at cycle 0 -> gnt=4'b0100, owner_id=2 at cycle 1; done pulse at cycle 5 -> gnt=0 at cycle 6, bus_busy=0.
REQ-032 Contention after reset: req=4'b1111, each owner pulses done after 2 cycles -> grant order 0,1,2,3,0, with a 2-cycle gap between tenures.
REQ-033 Wrap: ptr=3 with req=4'b1001 -> index 3 wins; next arbitration -> index 0 wins.
REQ-034 Owner drops req without done -> RELEASE next cycle; done[1] pulsed while owner is 2 -> ignored, gnt unchanged.
REQ-035 With BUS_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, owner never pulses done -> gnt drops after 16 grant cycles, timeout_err=1 for exactly 1 cycle; without the macro, grant is held for 100 cycles and timeout_err=0.
REQ-036 rst=0 asserted mid-GRANT -> gnt=0 immediately; after release of rst with req=4'b1010 -> index 1 is granted first.
